// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared RV32I(M) types for the decode/control pipeline: opcode and
// function-code encodings, mux select enums and the control word carried
// from EX through WB. Also holds the register-read helpers used by the
// load-use check.
package decode_ctrl_pipe_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  // Numbered so that funct3 of add/sll/xor/srl/or/and maps straight across.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    alumux2_i_imm = 3'd0,
    alumux2_u_imm = 3'd1,
    alumux2_b_imm = 3'd2,
    alumux2_s_imm = 3'd3,
    alumux2_j_imm = 3'd4,
    alumux2_rs2   = 3'd5
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    rf_alu_out  = 4'd0,
    rf_br_en    = 4'd1,
    rf_u_imm    = 4'd2,
    rf_lw       = 4'd3,
    rf_pc_plus4 = 4'd4,
    rf_lb       = 4'd5,
    rf_lbu      = 4'd6,
    rf_lh       = 4'd7,
    rf_lhu      = 4'd8
  } regfilemux_sel_t;

  localparam logic ALUMUX1_RS1 = 1'b0;
  localparam logic ALUMUX1_PC  = 1'b1;
  localparam logic CMPMUX_RS2  = 1'b0;
  localparam logic CMPMUX_IMM  = 1'b1;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    rv32i_opcode     opcode;
    alu_ops          aluop;
    logic            alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    branch_funct3_t  cmpop;
    logic            cmpmux_sel;
    regfilemux_sel_t regfilemux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      store_type;
    logic            muldiv;
    logic [2:0]      muldiv_op;
    logic            illegal;
  } rv32i_control_word;

  // rs1 is architecturally read by everything except lui/auipc/jal.
  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op == op_lui || op == op_auipc || op == op_jal);
  endfunction

  // rs2 is read only by branches, stores and register-register ops.
  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == op_br || op == op_store || op == op_reg);
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_ctrl_decode.sv
// ctrl_decode: purely combinational RV32I(M) instruction decode.
// Ports:
//   opcode, funct3, funct7 - instruction fields from ID
//   rd                     - destination index (suppresses x0 writes)
//   ctrl                   - decoded control word; unknown encodings give an
//                            all-zero word with illegal=1
// Parameter EN_MEXT enables the M-extension funct7 on register ops.
module ctrl_decode import decode_ctrl_pipe_pkg::*; #(
  parameter int EN_MEXT = 1
) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  output rv32i_control_word ctrl
);

  // ALU/compare selection shared by op_imm and op_reg. slt/sltu go through
  // the comparator and write back br_en.
  function automatic rv32i_control_word arith_ops(input rv32i_control_word base,
                                                  input logic [2:0] f3,
                                                  input logic alt_shift);
    rv32i_control_word w;
    w = base;
    w.load_regfile = 1'b1;
    case (f3)
      F3_SLT: begin
        w.cmpop          = blt;
        w.regfilemux_sel = rf_br_en;
      end
      F3_SLTU: begin
        w.cmpop          = bltu;
        w.regfilemux_sel = rf_br_en;
      end
      F3_SR:   w.aluop = alt_shift ? alu_sra : alu_srl;
      default: w.aluop = alu_ops'(f3);
    endcase
    return w;
  endfunction

  logic bad;

  always_comb begin
    ctrl        = '0;
    bad         = 1'b0;
    ctrl.opcode = rv32i_opcode'(opcode);
    case (opcode)
      op_lui: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = rf_u_imm;
      end
      op_auipc: begin
        ctrl.alumux1_sel  = ALUMUX1_PC;
        ctrl.alumux2_sel  = alumux2_u_imm;
        ctrl.load_regfile = 1'b1;
      end
      op_jal: begin
        ctrl.alumux1_sel    = ALUMUX1_PC;
        ctrl.alumux2_sel    = alumux2_j_imm;
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = rf_pc_plus4;
      end
      op_jalr: begin
        ctrl.alumux1_sel    = ALUMUX1_RS1;
        ctrl.alumux2_sel    = alumux2_i_imm;
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = rf_pc_plus4;
      end
      op_br: begin
        ctrl.alumux1_sel = ALUMUX1_PC;
        ctrl.alumux2_sel = alumux2_b_imm;
        ctrl.cmpop       = branch_funct3_t'(funct3);
        ctrl.cmpmux_sel  = CMPMUX_RS2;
      end
      op_load: begin
        ctrl.alumux2_sel  = alumux2_i_imm;
        ctrl.mem_read     = 1'b1;
        ctrl.load_regfile = 1'b1;
        case (funct3)
          F3_LB:   ctrl.regfilemux_sel = rf_lb;
          F3_LH:   ctrl.regfilemux_sel = rf_lh;
          F3_LBU:  ctrl.regfilemux_sel = rf_lbu;
          F3_LHU:  ctrl.regfilemux_sel = rf_lhu;
          default: ctrl.regfilemux_sel = rf_lw;
        endcase
      end
      op_store: begin
        ctrl.alumux2_sel = alumux2_s_imm;
        ctrl.mem_write   = 1'b1;
        ctrl.store_type  = funct3[1:0];
      end
      op_imm: begin
        ctrl.alumux2_sel = alumux2_i_imm;
        ctrl.cmpmux_sel  = CMPMUX_IMM;
        ctrl             = arith_ops(ctrl, funct3, funct7[5]);
      end
      op_reg: begin
        ctrl.alumux2_sel = alumux2_rs2;
        ctrl.cmpmux_sel  = CMPMUX_RS2;
        case (funct7)
          FUNCT7_BASE: ctrl = arith_ops(ctrl, funct3, 1'b0);
          FUNCT7_ALT: begin
            ctrl.load_regfile = 1'b1;
            if (funct3 == F3_ADD)     ctrl.aluop = alu_sub;
            else if (funct3 == F3_SR) ctrl.aluop = alu_sra;
            else                      bad = 1'b1;
          end
          FUNCT7_MEXT: begin
            if (EN_MEXT != 0) begin
              ctrl.muldiv       = 1'b1;
              ctrl.muldiv_op    = funct3;
              ctrl.load_regfile = 1'b1;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      op_csr: ;
      default: bad = 1'b1;
    endcase

    if (bad) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end else if (rd == 5'd0) begin
      ctrl.load_regfile = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: decodes the ID instruction and carries its control word
// through registered EX, MEM and WB stages, generating ID stall/flush.
// Ports:
//   clk, rst (sync, active-high)
//   id_valid, id_opcode, id_funct3, id_funct7, id_rd, id_rs1, id_rs2 - ID
//   mem_stall - freezes every stage; br_taken - EX redirect (flush IF/ID)
//   id_ready, if_flush - ID consume / IF-ID bubble controls
//   ex_/mem_/wb_ ctrl, valid, rd - per-stage control outputs
//   muldiv_busy - EX is holding an M-extension op
// Hazard priority: rst > mem_stall > br_taken > muldiv hold > load-use.
module decode_ctrl_pipe import decode_ctrl_pipe_pkg::*; #(
  parameter int EN_MEXT    = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              mem_stall,
  input  logic              br_taken,
  output logic              id_ready,
  output logic              if_flush,
  output rv32i_control_word ex_ctrl,
  output logic              ex_valid,
  output logic [4:0]        ex_rd,
  output rv32i_control_word mem_ctrl,
  output logic              mem_valid,
  output logic [4:0]        mem_rd,
  output rv32i_control_word wb_ctrl,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              muldiv_busy
);

  localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

  rv32i_control_word id_ctrl;
  logic [3:0]        cnt;
  logic              flush;
  logic              load_use;

  ctrl_decode #(.EN_MEXT(EN_MEXT)) u_decode (
    .opcode (id_opcode),
    .funct3 (id_funct3),
    .funct7 (id_funct7),
    .rd     (id_rd),
    .ctrl   (id_ctrl)
  );

  // A redirect only counts when a real instruction occupies EX.
  assign flush = br_taken & ex_valid;

  assign muldiv_busy = ex_valid & ex_ctrl.muldiv & (cnt != 4'd0);

  // x0 never carries a dependency; only sources the ID op really reads count.
  assign load_use = ex_valid && (ex_ctrl.opcode == op_load) && (ex_rd != 5'd0) &&
                    id_valid &&
                    ((reads_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
                     (reads_rs2(id_opcode) && (id_rs2 == ex_rd)));

  assign if_flush = !mem_stall & flush;
  assign id_ready = !mem_stall & (flush | (!muldiv_busy & !load_use));

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= '0;
      wb_rd     <= '0;
      cnt       <= '0;
    end else if (!mem_stall) begin
      // MEM -> WB: always shifts when not frozen
      wb_valid <= mem_valid;
      wb_ctrl  <= mem_ctrl;
      wb_rd    <= mem_rd;

      // EX -> MEM: bubble only while an M-op holds EX
      if (muldiv_busy && !flush) begin
        mem_valid <= 1'b0;
        mem_ctrl  <= '0;
        mem_rd    <= '0;
      end else begin
        mem_valid <= ex_valid;
        mem_ctrl  <= ex_ctrl;
        mem_rd    <= ex_rd;
      end

      // ID -> EX
      if (flush || (load_use && !muldiv_busy)) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_rd    <= '0;
        cnt      <= '0;
      end else if (muldiv_busy) begin
        cnt <= cnt - 4'd1;
      end else begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : '0;
        ex_rd    <= id_valid ? id_rd : 5'd0;
        cnt      <= (id_valid && id_ctrl.muldiv) ? LAT_M1 : 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;
  import decode_ctrl_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, mem_stall, br_taken;
  logic [6:0] id_opcode, id_funct7;
  logic [2:0] id_funct3;
  logic [4:0] id_rd, id_rs1, id_rs2;

  logic id_ready, if_flush, ex_valid, mem_valid, wb_valid, muldiv_busy;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  rv32i_control_word ex_ctrl, mem_ctrl, wb_ctrl;

  logic n_id_ready, n_if_flush, n_ex_valid, n_mem_valid, n_wb_valid, n_muldiv_busy;
  logic [4:0] n_ex_rd, n_mem_rd, n_wb_rd;
  rv32i_control_word n_ex_ctrl, n_mem_ctrl, n_wb_ctrl;

  decode_ctrl_pipe #(.EN_MEXT(1), .MULDIV_LAT(4)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .mem_stall(mem_stall), .br_taken(br_taken),
    .id_ready(id_ready), .if_flush(if_flush), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_valid(mem_valid), .mem_rd(mem_rd),
    .wb_ctrl(wb_ctrl), .wb_valid(wb_valid), .wb_rd(wb_rd), .muldiv_busy(muldiv_busy)
  );

  decode_ctrl_pipe #(.EN_MEXT(0), .MULDIV_LAT(4)) u_nom (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .mem_stall(mem_stall), .br_taken(br_taken),
    .id_ready(n_id_ready), .if_flush(n_if_flush), .ex_ctrl(n_ex_ctrl), .ex_valid(n_ex_valid),
    .ex_rd(n_ex_rd), .mem_ctrl(n_mem_ctrl), .mem_valid(n_mem_valid), .mem_rd(n_mem_rd),
    .wb_ctrl(n_wb_ctrl), .wb_valid(n_wb_valid), .wb_rd(n_wb_rd), .muldiv_busy(n_muldiv_busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [2:0] alu;
    logic [2:0] m2;
    logic [3:0] rf;
    logic [2:0] cmp;
    logic       ld;
    logic       rdm;
    logic       wr;
    logic       ill;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input int op, input int f3, input int f7, input int rd,
                              input int alu, input int m2, input int rf, input int cmp,
                              input int ld, input int rdm, input int wr, input int ill);
    vec_t v;
    v.op = 7'(op);   v.f3 = 3'(f3);   v.f7 = 7'(f7);   v.rd = 5'(rd);
    v.alu = 3'(alu); v.m2 = 3'(m2);   v.rf = 4'(rf);   v.cmp = 3'(cmp);
    v.ld = 1'(ld);   v.rdm = 1'(rdm); v.wr = 1'(wr);   v.ill = 1'(ill);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = v; id_opcode = op; id_funct3 = f3; id_funct7 = f7;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          op    f3 f7    rd  alu m2 rf cmp ld rd wr ill
    vecs[0]  = mk('h33, 0, 'h00, 3,  0, 5, 0, 0, 1, 0, 0, 0); // add
    vecs[1]  = mk('h33, 0, 'h20, 4,  3, 5, 0, 0, 1, 0, 0, 0); // sub
    vecs[2]  = mk('h33, 5, 'h20, 4,  2, 5, 0, 0, 1, 0, 0, 0); // sra
    vecs[3]  = mk('h33, 3, 'h00, 4,  0, 5, 1, 6, 1, 0, 0, 0); // sltu
    vecs[4]  = mk('h33, 7, 'h00, 4,  7, 5, 0, 0, 1, 0, 0, 0); // and
    vecs[5]  = mk('h33, 0, 'h00, 0,  0, 5, 0, 0, 0, 0, 0, 0); // add x0
    vecs[6]  = mk('h13, 0, 'h00, 0,  0, 0, 0, 0, 0, 0, 0, 0); // addi x0
    vecs[7]  = mk('h13, 2, 'h00, 9,  0, 0, 1, 4, 1, 0, 0, 0); // slti
    vecs[8]  = mk('h13, 5, 'h20, 9,  2, 0, 0, 0, 1, 0, 0, 0); // srai
    vecs[9]  = mk('h13, 5, 'h00, 9,  5, 0, 0, 0, 1, 0, 0, 0); // srli
    vecs[10] = mk('h13, 4, 'h00, 9,  4, 0, 0, 0, 1, 0, 0, 0); // xori
    vecs[11] = mk('h03, 2, 'h00, 5,  0, 0, 3, 0, 1, 1, 0, 0); // lw
    vecs[12] = mk('h03, 4, 'h00, 5,  0, 0, 6, 0, 1, 1, 0, 0); // lbu
    vecs[13] = mk('h03, 1, 'h00, 5,  0, 0, 7, 0, 1, 1, 0, 0); // lh
    vecs[14] = mk('h23, 2, 'h00, 4,  0, 3, 0, 0, 0, 0, 1, 0); // sw
    vecs[15] = mk('h63, 5, 'h00, 0,  0, 2, 0, 5, 0, 0, 0, 0); // bge
    vecs[16] = mk('h37, 0, 'h00, 10, 0, 0, 2, 0, 1, 0, 0, 0); // lui
    vecs[17] = mk('h17, 0, 'h00, 10, 0, 1, 0, 0, 1, 0, 0, 0); // auipc
    vecs[18] = mk('h6F, 0, 'h00, 1,  0, 4, 4, 0, 1, 0, 0, 0); // jal
    vecs[19] = mk('h67, 0, 'h00, 1,  0, 0, 4, 0, 1, 0, 0, 0); // jalr
    vecs[20] = mk('h33, 0, 'h02, 3,  0, 0, 0, 0, 0, 0, 0, 1); // bad funct7
    vecs[21] = mk('h7F, 0, 'h00, 3,  0, 0, 0, 0, 0, 0, 0, 1); // unknown opcode
    vecs[22] = mk('h73, 0, 'h00, 0,  0, 0, 0, 0, 0, 0, 0, 0); // csr

    rst = 1'b1; mem_stall = 1'b0; br_taken = 1'b0;
    drive(1'b1, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2);

    // Reset with a valid instruction presented
    tick();
    check("reset_ex_valid_in_rst", 64'(ex_valid), 64'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
    #1;
    check("reset_valids", 64'({ex_valid, mem_valid, wb_valid}), 64'd0);
    check("reset_ex_ctrl", 64'(ex_ctrl), 64'd0);
    check("reset_mem_ctrl", 64'(mem_ctrl), 64'd0);
    check("reset_wb_ctrl", 64'(wb_ctrl), 64'd0);
    check("reset_rds", 64'({ex_rd, mem_rd, wb_rd}), 64'd0);
    check("reset_busy", 64'(muldiv_busy), 64'd0);
    check("reset_id_ready", 64'(id_ready), 64'd1);

    // Decode table
    for (int i = 0; i < 23; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rd, 5'd1, 5'd2);
      tick();
      check($sformatf("decode[%0d]", i),
            64'({ex_valid, ex_rd, ex_ctrl.opcode, ex_ctrl.aluop, ex_ctrl.alumux2_sel,
                 ex_ctrl.regfilemux_sel, ex_ctrl.cmpop, ex_ctrl.load_regfile,
                 ex_ctrl.mem_read, ex_ctrl.mem_write, ex_ctrl.illegal}),
            64'({1'b1, vecs[i].rd, (vecs[i].ill ? 7'd0 : vecs[i].op), vecs[i].alu,
                 vecs[i].m2, vecs[i].rf, vecs[i].cmp, vecs[i].ld, vecs[i].rdm,
                 vecs[i].wr, vecs[i].ill}));
      idle(1);
    end
    idle(3);

    // Straight ALU flow: add x3,x1,x2 ; sub x4,x3,x1
    drive(1'b1, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2);
    #1 check("alu_ready0", 64'(id_ready), 64'd1);
    tick();
    check("alu_ex_add", 64'({ex_valid, ex_rd, ex_ctrl.aluop}), 64'({1'b1, 5'd3, 3'd0}));
    drive(1'b1, 7'h33, 3'd0, 7'h20, 5'd4, 5'd3, 5'd1);
    #1 check("alu_ready1", 64'(id_ready), 64'd1);
    tick();
    check("alu_ex_sub", 64'({ex_valid, ex_rd, ex_ctrl.aluop}), 64'({1'b1, 5'd4, 3'd3}));
    check("alu_mem_add", 64'({mem_valid, mem_rd}), 64'({1'b1, 5'd3}));
    drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
    tick();
    check("alu_wb_add", 64'({wb_valid, wb_rd}), 64'({1'b1, 5'd3}));
    idle(3);

    // Load-use: lw x5,0(x1) ; add x6,x5,x2
    drive(1'b1, 7'h03, 3'd2, 7'h00, 5'd5, 5'd1, 5'd0);
    tick();
    drive(1'b1, 7'h33, 3'd0, 7'h00, 5'd6, 5'd5, 5'd2);
    #1 check("lu_stall", 64'({id_ready, ex_rd}), 64'({1'b0, 5'd5}));
    tick();
    check("lu_bubble", 64'({ex_valid, mem_valid, mem_rd}), 64'({1'b0, 1'b1, 5'd5}));
    check("lu_release", 64'(id_ready), 64'd1);
    tick();
    check("lu_add_in_ex", 64'({ex_valid, ex_rd, wb_rd}), 64'({1'b1, 5'd6, 5'd5}));
    idle(3);

    // lw x5 then lui x5 (rs1 field not read): no stall
    drive(1'b1, 7'h03, 3'd2, 7'h00, 5'd5, 5'd1, 5'd0);
    tick();
    drive(1'b1, 7'h37, 3'd0, 7'h00, 5'd5, 5'd5, 5'd5);
    #1 check("lu_lui_nostall", 64'(id_ready), 64'd1);
    idle(3);

    // lw x0 then add x6,x0,x0: no stall
    drive(1'b1, 7'h03, 3'd2, 7'h00, 5'd0, 5'd1, 5'd0);
    tick();
    drive(1'b1, 7'h33, 3'd0, 7'h00, 5'd6, 5'd0, 5'd0);
    #1 check("lu_x0_nostall", 64'(id_ready), 64'd1);
    tick();
    check("lu_x0_ex", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd6}));
    idle(3);

    // lw x5 then sw x5,0(x1): rs2 dependency stalls
    drive(1'b1, 7'h03, 3'd2, 7'h00, 5'd5, 5'd1, 5'd0);
    tick();
    drive(1'b1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd5);
    #1 check("lu_store_rs2", 64'(id_ready), 64'd0);
    idle(3);

    // Mul hold: mul x7,x1,x2 followed by add x8
    drive(1'b1, 7'h33, 3'd0, 7'h01, 5'd7, 5'd1, 5'd2);
    #1 check("mul_accept", 64'(id_ready), 64'd1);
    tick();
    check("mul_ex", 64'({ex_valid, ex_rd, ex_ctrl.muldiv, ex_ctrl.muldiv_op}),
          64'({1'b1, 5'd7, 1'b1, 3'd0}));
    check("nom_illegal", 64'({n_ex_ctrl.illegal, n_ex_ctrl.muldiv}), 64'({1'b1, 1'b0}));
    drive(1'b1, 7'h33, 3'd0, 7'h00, 5'd8, 5'd1, 5'd2);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mul_hold[%0d]", i), 64'({muldiv_busy, id_ready, ex_rd}),
            64'({(i < 3), (i == 3), 5'd7}));
      check($sformatf("nom_nohold[%0d]", i), 64'({n_muldiv_busy, n_id_ready}), 64'({1'b0, 1'b1}));
      tick();
      if (i < 3) check($sformatf("mul_mem_bubble[%0d]", i), 64'(mem_valid), 64'd0);
    end
    check("mul_advance", 64'({ex_rd, mem_valid, mem_rd, mem_ctrl.muldiv}),
          64'({5'd8, 1'b1, 5'd7, 1'b1}));
    idle(4);

    // Reset in the middle of a hold
    drive(1'b1, 7'h33, 3'd4, 7'h01, 5'd7, 5'd1, 5'd2);
    tick();
    drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check("rst_mid_hold", 64'({ex_valid, muldiv_busy, id_ready}), 64'({1'b0, 1'b0, 1'b1}));
    drive(1'b1, 7'h33, 3'd0, 7'h00, 5'd8, 5'd1, 5'd2);
    tick();
    drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
    check("rst_mid_hold_add", 64'({ex_rd, muldiv_busy}), 64'({5'd8, 1'b0}));
    tick();
    check("rst_mid_hold_adv", 64'({mem_valid, mem_rd}), 64'({1'b1, 5'd8}));
    idle(3);

    // Memory freeze mid-mul
    drive(1'b1, 7'h33, 3'd0, 7'h01, 5'd7, 5'd1, 5'd2);
    tick();
    drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
    tick();
    mem_stall = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("freeze[%0d]", k),
            64'({ex_valid, ex_rd, muldiv_busy, id_ready, if_flush, mem_valid, wb_valid}),
            64'({1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
      tick();
    end
    mem_stall = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("freeze_resume[%0d]", j), 64'({muldiv_busy, ex_rd}), 64'({(j < 2), 5'd7}));
      tick();
    end
    check("freeze_advance", 64'({ex_valid, mem_valid, mem_rd}), 64'({1'b0, 1'b1, 5'd7}));
    idle(3);

    // Load-use under mem_stall: bubble on first unstalled cycle
    drive(1'b1, 7'h03, 3'd2, 7'h00, 5'd5, 5'd1, 5'd0);
    tick();
    drive(1'b1, 7'h33, 3'd0, 7'h00, 5'd6, 5'd5, 5'd2);
    mem_stall = 1'b1;
    #1 check("lus_stalled", 64'(id_ready), 64'd0);
    tick();
    check("lus_held", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd5}));
    tick();
    mem_stall = 1'b0;
    #1 check("lus_first_free", 64'(id_ready), 64'd0);
    tick();
    check("lus_bubble", 64'({ex_valid, mem_rd, id_ready}), 64'({1'b0, 5'd5, 1'b1}));
    tick();
    check("lus_add", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd6}));
    idle(3);

    // Branch flush: beq resolved taken in EX
    drive(1'b1, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2);
    tick();
    drive(1'b1, 7'h33, 3'd0, 7'h00, 5'd9, 5'd1, 5'd2);
    br_taken = 1'b1;
    #1 check("br_flush", 64'({if_flush, id_ready}), 64'({1'b1, 1'b1}));
    tick();
    br_taken = 1'b0;
    drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
    check("br_bubble", 64'({ex_valid, mem_valid, mem_ctrl.opcode}), 64'({1'b0, 1'b1, 7'h63}));
    idle(3);

    // Flush wins over a simultaneous load-use
    drive(1'b1, 7'h03, 3'd2, 7'h00, 5'd5, 5'd1, 5'd0);
    tick();
    drive(1'b1, 7'h33, 3'd0, 7'h00, 5'd6, 5'd5, 5'd2);
    br_taken = 1'b1;
    #1 check("br_vs_lu", 64'({if_flush, id_ready}), 64'({1'b1, 1'b1}));
    tick();
    br_taken = 1'b0;
    drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
    check("br_vs_lu_ex", 64'({ex_valid, mem_rd}), 64'({1'b0, 5'd5}));
    idle(3);

    // br_taken with an empty EX is ignored
    br_taken = 1'b1;
    #1 check("br_no_ex", 64'({if_flush, id_ready}), 64'({1'b0, 1'b1}));
    br_taken = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
